// File: rtl/fcn_pkg.sv
// Shared types and helpers for the fully-connected layer sequencer:
// FSM state encoding, drain length and the output shift/saturate function.
package fcn_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Cycles between the last LOAD and WRITE so the final product reaches acc.
    localparam int unsigned DRAIN_CYCLES = 32'd2;

    // Working width for sat_shift; any accumulator up to this width fits.
    localparam int unsigned SAT_W = 32'd128;

    function automatic logic signed [SAT_W-1:0] sat_shift(
        input logic signed [SAT_W-1:0] val,
        input int unsigned             shift,
        input int unsigned             dw
    );
        logic signed [SAT_W-1:0] shifted;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        logic signed [SAT_W-1:0] res;
        shifted = val >>> shift;
        max_v   = (128'sd1 <<< (dw - 32'd1)) - 128'sd1;
        min_v   = -(128'sd1 <<< (dw - 32'd1));
        if (shifted > max_v) begin
            res = max_v;
        end else if (shifted < min_v) begin
            res = min_v;
        end else begin
            res = shifted;
        end
        return res;
    endfunction

endpackage

// File: rtl/fcn_layer_ctrl_if.sv
// The three BRAM ports of the FCN datapath: input vector, weight matrix, result.
// master = sequencer side, slave = memory side.
interface fcn_layer_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic                  ce_input;
    logic                  we_input;
    logic [ADDR_WIDTH-1:0] addr_input;
    logic [DATA_WIDTH-1:0] qout_input;
    logic                  ce_weight;
    logic                  we_weight;
    logic [ADDR_WIDTH-1:0] addr_weight;
    logic [DATA_WIDTH-1:0] qout_weight;
    logic                  ce_c;
    logic                  we_c;
    logic [ADDR_WIDTH-1:0] addr_c;
    logic [DATA_WIDTH-1:0] din_c;

    modport master (
        output ce_input, we_input, addr_input,
        input  qout_input,
        output ce_weight, we_weight, addr_weight,
        input  qout_weight,
        output ce_c, we_c, addr_c, din_c
    );

    modport slave (
        input  ce_input, we_input, addr_input,
        output qout_input,
        input  ce_weight, we_weight, addr_weight,
        output qout_weight,
        input  ce_c, we_c, addr_c, din_c
    );
endinterface

// File: rtl/fcn_mac_pipe.sv
// Three-stage MAC: BRAM data valid -> registered full-width product -> accumulator.
// A valid bit follows each operand pair through the stages.
module fcn_mac_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 76
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid,
    input  logic signed [DATA_WIDTH-1:0] op_a,
    input  logic signed [DATA_WIDTH-1:0] op_b,
    input  logic                         clear,
    output logic signed [ACC_WIDTH-1:0]  acc
);
    localparam int PW = 2 * DATA_WIDTH;

    logic                    data_vld_r;
    logic                    prod_vld_r;
    logic signed [PW-1:0]    prod_r;
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic signed [PW-1:0]    a_ext_s;
    logic signed [PW-1:0]    b_ext_s;

    assign a_ext_s = PW'(op_a);
    assign b_ext_s = PW'(op_b);

    // valid bits, product register and accumulator
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_vld_r <= 1'b0;
            prod_vld_r <= 1'b0;
            prod_r     <= '0;
            acc_r      <= '0;
        end else begin
            data_vld_r <= valid;
            prod_vld_r <= data_vld_r;
            if (data_vld_r) begin
                prod_r <= a_ext_s * b_ext_s;
            end else begin
                prod_r <= '0;
            end
            if (clear) begin
                acc_r <= '0;
            end else if (prod_vld_r) begin
                acc_r <= acc_r + ACC_WIDTH'(prod_r);
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    assign acc = acc_r;
endmodule

// File: rtl/fcn_layer_ctrl.sv
// Fully-connected layer sequencer: streams input and row-major weights per neuron,
// accumulates through fcn_mac_pipe and writes one saturated (optionally ReLU'd) word per neuron.
module fcn_layer_ctrl
    import fcn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int MEM_SIZE   = 4096,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + ADDR_WIDTH,
    parameter int OUT_SHIFT  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_run,
    input  logic [ADDR_WIDTH-1:0] i_num_in,
    input  logic [ADDR_WIDTH-1:0] i_num_out,
    input  logic                  i_relu,
    output logic                  o_idle,
    output logic                  o_busy,
    output logic                  o_done,
    fcn_layer_ctrl_if.master      bram
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [1:0]            DRAIN_END = 2'(DRAIN_CYCLES - 32'd1);

    state_e                       state_r;
    logic [ADDR_WIDTH-1:0]        n_in_r;
    logic [ADDR_WIDTH-1:0]        n_out_r;
    logic                         relu_r;
    logic [ADDR_WIDTH-1:0]        i_r;
    logic [ADDR_WIDTH-1:0]        j_r;
    logic [ADDR_WIDTH-1:0]        wptr_r;
    logic [1:0]                   drain_r;
    logic signed [ACC_WIDTH-1:0]  acc_s;
    logic signed [SAT_W-1:0]      sat_full_s;
    logic [DATA_WIDTH-1:0]        sat_s;
    logic [DATA_WIDTH-1:0]        din_s;
    logic                         load_s;
    logic                         write_s;

    // FSM, loop counters and weight pointer
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            n_in_r  <= '0;
            n_out_r <= '0;
            relu_r  <= 1'b0;
            i_r     <= '0;
            j_r     <= '0;
            wptr_r  <= '0;
            drain_r <= 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_run) begin
                        n_in_r  <= i_num_in;
                        n_out_r <= i_num_out;
                        relu_r  <= i_relu;
                        i_r     <= '0;
                        j_r     <= '0;
                        wptr_r  <= '0;
                        drain_r <= 2'd0;
                        if ((i_num_in == '0) || (i_num_out == '0)) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= LOAD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    wptr_r <= wptr_r + ADDR_ONE;
                    if (i_r == n_in_r - ADDR_ONE) begin
                        i_r     <= '0;
                        drain_r <= 2'd0;
                        state_r <= DRAIN;
                    end else begin
                        i_r <= i_r + ADDR_ONE;
                    end
                end
                DRAIN: begin
                    if (drain_r == DRAIN_END) begin
                        drain_r <= 2'd0;
                        state_r <= WRITE;
                    end else begin
                        drain_r <= drain_r + 2'd1;
                    end
                end
                WRITE: begin
                    j_r <= j_r + ADDR_ONE;
                    if (j_r == n_out_r - ADDR_ONE) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= LOAD;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign load_s  = (state_r == LOAD);
    assign write_s = (state_r == WRITE);

    fcn_mac_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .valid (load_s),
        .op_a  (bram.qout_input),
        .op_b  (bram.qout_weight),
        .clear (write_s),
        .acc   (acc_s)
    );

    // output word: shift, clamp to DATA_WIDTH, then optional ReLU
    always_comb begin
        sat_full_s = sat_shift(SAT_W'(acc_s), OUT_SHIFT, DATA_WIDTH);
        sat_s      = sat_full_s[DATA_WIDTH-1:0];
        if (write_s) begin
            if (relu_r && sat_s[DATA_WIDTH-1]) begin
                din_s = '0;
            end else begin
                din_s = sat_s;
            end
        end else begin
            din_s = '0;
        end
    end

    // Addresses are gated to zero outside their active state.
    assign o_idle           = (state_r == IDLE);
    assign o_busy           = load_s || (state_r == DRAIN) || write_s;
    assign o_done           = (state_r == DONE);
    assign bram.ce_input    = load_s;
    assign bram.we_input    = 1'b0;
    assign bram.addr_input  = load_s ? i_r : '0;
    assign bram.ce_weight   = load_s;
    assign bram.we_weight   = 1'b0;
    assign bram.addr_weight = load_s ? wptr_r : '0;
    assign bram.ce_c        = write_s;
    assign bram.we_c        = write_s;
    assign bram.addr_c      = write_s ? j_r : '0;
    assign bram.din_c       = din_s;
endmodule

// File: tb/tb_fcn_layer_ctrl.sv
// Directed bench for fcn_layer_ctrl: two instances (OUT_SHIFT 0 and 4) share the
// BRAM contents; a vector table plus hand sequences for busy-run and mid-op reset.
module tb_fcn_layer_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_run = 1'b0;
    logic [11:0] i_num_in = 12'd0;
    logic [11:0] i_num_out = 12'd0;
    logic        i_relu = 1'b0;
    logic        idle0, busy0, done0, idle1, busy1, done1;

    fcn_layer_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bif0 ();
    fcn_layer_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bif1 ();

    fcn_layer_ctrl #(.OUT_SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .i_run(i_run), .i_num_in(i_num_in),
        .i_num_out(i_num_out), .i_relu(i_relu), .o_idle(idle0), .o_busy(busy0),
        .o_done(done0), .bram(bif0)
    );
    fcn_layer_ctrl #(.OUT_SHIFT(4)) dut1 (
        .clk(clk), .reset(reset), .i_run(i_run), .i_num_in(i_num_in),
        .i_num_out(i_num_out), .i_relu(i_relu), .o_idle(idle1), .o_busy(busy1),
        .o_done(done1), .bram(bif1)
    );

    always #5 clk = ~clk;

    logic [31:0] in_mem [16];
    logic [31:0] w_mem  [16];
    logic [31:0] out0   [16];
    logic [31:0] out1   [16];
    int          wr0, wr1, act0;
    logic        log_clr = 1'b0;

    always @(posedge clk) begin
        if (bif0.ce_input)  bif0.qout_input  <= in_mem[bif0.addr_input[3:0]];
        if (bif0.ce_weight) bif0.qout_weight <= w_mem[bif0.addr_weight[3:0]];
        if (bif1.ce_input)  bif1.qout_input  <= in_mem[bif1.addr_input[3:0]];
        if (bif1.ce_weight) bif1.qout_weight <= w_mem[bif1.addr_weight[3:0]];
    end

    always @(posedge clk) begin
        if (log_clr) begin
            for (int k = 0; k < 16; k++) begin
                out0[k] <= 32'hDEADBEEF;
                out1[k] <= 32'hDEADBEEF;
            end
            wr0  <= 0;
            wr1  <= 0;
            act0 <= 0;
        end else begin
            if (bif0.ce_c && bif0.we_c) begin
                out0[bif0.addr_c[3:0]] <= bif0.din_c;
                wr0 <= wr0 + 1;
            end
            if (bif1.ce_c && bif1.we_c) begin
                out1[bif1.addr_c[3:0]] <= bif1.din_c;
                wr1 <= wr1 + 1;
            end
            if (bif0.ce_input || bif0.ce_weight || bif0.ce_c || bif0.we_input || bif0.we_weight)
                act0 <= act0 + 1;
        end
    end

    typedef struct {
        int               n_in;
        int               n_out;
        logic             relu;
        logic [3:0][31:0] in_v;
        logic [5:0][31:0] w_v;
        logic [1:0][31:0] exp0;
        logic [1:0][31:0] exp1;
        int               lat;
    } vec_t;

    vec_t vecs [8];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load_mem(input vec_t v);
        for (int k = 0; k < 16; k++) begin
            in_mem[k] = (k < 4) ? v.in_v[k] : 32'd0;
            w_mem[k]  = (k < 6) ? v.w_v[k]  : 32'd0;
        end
    endtask

    // Called at #1 after an edge; returns at #1 after the edge that samples i_run.
    task automatic start_run(input int n_in, input int n_out, input logic relu);
        log_clr = 1'b1;
        @(posedge clk); #1;
        log_clr   = 1'b0;
        i_run     = 1'b1;
        i_num_in  = 12'(n_in);
        i_num_out = 12'(n_out);
        i_relu    = relu;
        @(posedge clk); #1;
        i_run = 1'b0;
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (!done0 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_tail(input string name);
        @(posedge clk); #1;
        check({name, "_done_width"}, {31'd0, done0}, 32'd0);
        check({name, "_idle_after"}, {31'd0, idle0}, 32'd1);
    endtask

    int lat;

    initial begin
        vecs[0] = '{3, 2, 1'b0, {32'd0, 32'd3, 32'd2, 32'd1},
                    {32'd2, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd1},
                    {32'd5, 32'd6}, {32'd0, 32'd0}, 13};
        vecs[1] = '{3, 2, 1'b1, {32'd0, 32'd3, 32'd2, 32'd1},
                    {32'd0, 32'd0, 32'hFFFFFFFC, 32'd1, 32'd1, 32'd1},
                    {32'd0, 32'd6}, {32'd0, 32'd0}, 13};
        vecs[2] = '{3, 2, 1'b0, {32'd0, 32'd3, 32'd2, 32'd1},
                    {32'd0, 32'd0, 32'hFFFFFFFC, 32'd1, 32'd1, 32'd1},
                    {32'hFFFFFFFC, 32'd6}, {32'hFFFFFFFF, 32'd0}, 13};
        vecs[3] = '{2, 1, 1'b0, {32'd0, 32'd0, 32'h40000000, 32'h40000000},
                    {32'd0, 32'd0, 32'd0, 32'd0, 32'h40000000, 32'h40000000},
                    {32'd0, 32'h7FFFFFFF}, {32'd0, 32'h7FFFFFFF}, 6};
        vecs[4] = '{2, 1, 1'b0, {32'd0, 32'd0, 32'h40000000, 32'h40000000},
                    {32'd0, 32'd0, 32'd0, 32'd0, 32'hC0000000, 32'hC0000000},
                    {32'd0, 32'h80000000}, {32'd0, 32'h80000000}, 6};
        vecs[5] = '{2, 1, 1'b0, {32'd0, 32'd0, 32'd6, 32'd10},
                    {32'd0, 32'd0, 32'd0, 32'd0, 32'd10, 32'd10},
                    {32'd0, 32'd160}, {32'd0, 32'd10}, 6};
        vecs[6] = '{0, 2, 1'b0, {32'd0, 32'd3, 32'd2, 32'd1},
                    {32'd2, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd1},
                    {32'd0, 32'd0}, {32'd0, 32'd0}, 1};
        vecs[7] = '{3, 0, 1'b0, {32'd0, 32'd3, 32'd2, 32'd1},
                    {32'd2, 32'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd1},
                    {32'd0, 32'd0}, {32'd0, 32'd0}, 1};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_idle", {31'd0, idle0}, 32'd1);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_ce", {29'd0, bif0.ce_input, bif0.ce_weight, bif0.ce_c}, 32'd0);
        check("rst_din", bif0.din_c, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            load_mem(vecs[v]);
            start_run(vecs[v].n_in, vecs[v].n_out, vecs[v].relu);
            check($sformatf("v%0d_busy_or_done", v), {31'd0, busy0 | done0}, 32'd1);
            wait_done(1, lat);
            check($sformatf("v%0d_done_lat", v), lat, vecs[v].lat);
            check($sformatf("v%0d_busy_in_done", v), {31'd0, busy0 | idle0}, 32'd0);
            if (vecs[v].n_in == 0 || vecs[v].n_out == 0) begin
                check($sformatf("v%0d_no_activity", v), act0, 32'd0);
                check($sformatf("v%0d_no_writes", v), wr0, 32'd0);
            end else begin
                check($sformatf("v%0d_writes0", v), wr0, vecs[v].n_out);
                check($sformatf("v%0d_writes1", v), wr1, vecs[v].n_out);
                for (int k = 0; k < vecs[v].n_out; k++) begin
                    check($sformatf("v%0d_s0_addr%0d", v, k), out0[k], vecs[v].exp0[k]);
                    check($sformatf("v%0d_s4_addr%0d", v, k), out1[k], vecs[v].exp1[k]);
                end
            end
            check_tail($sformatf("v%0d", v));
        end

        // run pulse and size changes while busy are ignored
        load_mem(vecs[0]);
        start_run(3, 2, 1'b0);
        @(posedge clk); #1;
        i_run = 1'b1; i_num_in = 12'd1; i_num_out = 12'd1; i_relu = 1'b1;
        @(posedge clk); #1;
        i_run = 1'b0;
        wait_done(3, lat);
        check("busy_run_lat", lat, 32'd13);
        check("busy_run_writes", wr0, 32'd2);
        check("busy_run_addr0", out0[0], 32'd6);
        check("busy_run_addr1", out0[1], 32'd5);
        check_tail("busy_run");

        // reset during the second neuron's LOAD
        start_run(3, 2, 1'b0);
        repeat (7) begin @(posedge clk); #1; end
        check("mid_in_load", {31'd0, bif0.ce_input}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_idle", {31'd0, idle0}, 32'd1);
        check("mid_rst_ce_we", {27'd0, bif0.ce_input, bif0.ce_weight, bif0.ce_c,
                                bif0.we_c, busy0}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_no_write", {31'd0, bif0.we_c}, 32'd0);
        check("mid_rst_writes", wr0, 32'd1);
        check("mid_rst_addr0", out0[0], 32'd6);
        start_run(3, 2, 1'b0);
        wait_done(1, lat);
        check("rerun_lat", lat, 32'd13);
        check("rerun_addr0", out0[0], 32'd6);
        check("rerun_addr1", out0[1], 32'd5);
        check_tail("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fcn_layer_ctrl.md
Name: fcn_layer_ctrl

Overview:
- Sequencer for one fully-connected layer.
- Streams the input vector from the input BRAM and the weight matrix from the weight BRAM, then multiply-accumulates them in a 3-stage pipeline.
- Writes one saturated, optionally ReLU'd result per output neuron to the output BRAM.
- Sits between the top-level run/status interface and the three BRAM ports of the FCN datapath. It replaces the plain data mover in the compute path.

Parameters:
- DATA_WIDTH, 32: width of input, weight and output words, signed two's complement.
- ADDR_WIDTH, 12: width of all BRAM addresses and of the size inputs.
- MEM_SIZE, 4096: BRAM depth in words. The product i_num_in*i_num_out must not exceed it.
- ACC_WIDTH, 2*DATA_WIDTH+ADDR_WIDTH: accumulator width. No overflow is possible inside the accumulator.
- OUT_SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-low
- i_run  in  1  start pulse, sampled only in IDLE
- i_num_in  in  ADDR_WIDTH  inputs per neuron (N_IN)
- i_num_out  in  ADDR_WIDTH  neuron count (N_OUT)
- i_relu  in  1  enable ReLU on outputs
- o_idle  out  1  high in IDLE
- o_busy  out  1  high in LOAD/DRAIN/WRITE
- o_done  out  1  one-cycle pulse at completion
- ce_input, we_input  out  1 each  input BRAM enable / write enable (we_input is always 0)
- addr_input  out  ADDR_WIDTH  input BRAM address
- qout_input  in  DATA_WIDTH  input BRAM data, 1-cycle read latency
- ce_weight, we_weight  out  1 each  weight BRAM enable / write enable (we_weight is always 0)
- addr_weight  out  ADDR_WIDTH  weight BRAM address
- qout_weight  in  DATA_WIDTH  weight BRAM data, 1-cycle read latency
- ce_c, we_c  out  1 each  output BRAM enable / write enable
- addr_c  out  ADDR_WIDTH  output BRAM address
- din_c  out  DATA_WIDTH  output BRAM write data

Behaviour:
- Reset (reset==0 at a clk edge): FSM goes to IDLE, all counters, pointers, the accumulator and the pipeline valid bits clear to 0, and every output drives 0 except o_idle=1. Reset applies immediately, including mid-operation; no BRAM write can occur in the cycle after reset.
- FSM states: IDLE, LOAD, DRAIN, WRITE, DONE.
- IDLE:
  - On i_run=1, latch i_num_in, i_num_out and i_relu.
  - If either size is 0, go to DONE with no BRAM writes; otherwise go to LOAD, with i=0, j=0, wptr=0 and acc=0.
- LOAD: lasts N_IN cycles.
  - ce_input=ce_weight=1, addr_input=i, addr_weight=wptr.
  - i and wptr increment every cycle.
  - On the last cycle (i==N_IN-1), clear i and go to DRAIN.
- Pipeline:
  - Stage 1: BRAM data is valid the cycle after the address is issued.
  - Stage 2: the signed product is registered, full 2*DATA_WIDTH bits.
  - Stage 3: acc <= acc + sign-extended product.
  - A valid bit travels with each stage.
- DRAIN: exactly 2 cycles, with all ce outputs at 0. At the exit edge the last product has been accumulated.
- WRITE: 1 cycle.
  - ce_c=we_c=1, addr_c=j.
  - din_c = sat(acc >>> OUT_SHIFT), where sat clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; then, if relu is latched and the value is negative, it becomes 0.
  - acc clears to 0 and j increments.
  - If j==N_OUT-1, go to DONE; otherwise go to LOAD. wptr continues and is never recomputed, so the weight layout is row-major: w[j*N_IN+i].
- Timing: each neuron takes N_IN+3 cycles. o_done is asserted in the DONE state for exactly 1 cycle, N_OUT*(N_IN+3)+1 cycles after the i_run edge. DONE returns to IDLE on the next edge.
- Ignored inputs: i_run while not in IDLE is ignored. Changes to the size and relu inputs after latching are ignored.
- wptr wraps modulo 2^ADDR_WIDTH. Sizes exceeding MEM_SIZE produce defined but meaningless addresses and must not hang the FSM.
- o_busy and o_idle are mutually exclusive, and both are 0 in DONE.

Decomposition:
- Package fcn_pkg holds:
  - the state enum typedef (IDLE, LOAD, DRAIN, WRITE, DONE);
  - the DRAIN_CYCLES=2 constant;
  - a sat_shift function (arithmetic shift, then clamp to DATA_WIDTH).
- Sub-module fcn_mac_pipe:
  - inputs: valid, two signed operands, clear;
  - contains the product register, the accumulator register and the valid pipeline;
  - outputs acc.
- The FSM, counters and address generation live in fcn_layer_ctrl.

Test Plan:
- Basic: N_IN=3, N_OUT=2, inputs [1,2,3], weights [1,1,1,-1,0,2], OUT_SHIFT=0, relu=0 -> writes addr0=6, addr1=5. o_done pulses 13 cycles after the run edge.
- ReLU: same as Basic but weights row1 = [-4,0,0], relu=1 -> addr1=0. With relu=0 -> addr1=-4 (0xFFFFFFFC).
- Saturation:
  - inputs [2^30,2^30], weights [2^30,2^30], N_OUT=1 -> din_c=0x7FFFFFFF.
  - Negated weights -> 0x80000000.
  - OUT_SHIFT=4 with acc=160 -> 10.
- Zero size: i_num_in=0 or i_num_out=0 -> no ce/we activity, o_done pulses 1 cycle after run, then o_idle=1.
- Run while busy: i_run pulsed mid-LOAD with different sizes -> ignored. Results and done timing are identical to the Basic case.
- Reset mid-op: reset=0 during the second neuron's LOAD -> the next cycle has o_idle=1 and all ce/we=0, with only addr0 written. A fresh run then completes correctly.
